// File: rtl/pc_if.sv
// rtl/pc_if.sv - ONC-16 program counter bus: branch operands, selects and PC output.
// Optional macro PC_STALL_EN adds the stall input.
`ifndef DATA_W
`define DATA_W 16
`endif

interface pc_if;
  logic [`DATA_W-1:0] imm;
  logic [`DATA_W-1:0] rs;
  logic               imr_sel;
  logic               br_sel;
`ifdef PC_STALL_EN
  logic               stall;
`endif
  logic [`DATA_W-1:0] out;

  modport master (
`ifdef PC_STALL_EN
    output stall,
`endif
    output imm, rs, imr_sel, br_sel,
    input  out
  );

  modport slave (
`ifdef PC_STALL_EN
    input  stall,
`endif
    input  imm, rs, imr_sel, br_sel,
    output out
  );
endinterface

// File: rtl/pc.sv
// rtl/pc.sv - ONC-16 program counter: increment, PC-relative or register-absolute branch.
// Optional macro PC_STALL_EN: stall input holds the PC (reset still wins).
`ifndef DATA_W
`define DATA_W 16
`endif

module pc (
  input  logic clock,
  input  logic n_rst,
  pc_if.slave  bus
);

  localparam logic [`DATA_W-1:0] RESET_PC = 16'h0000;

  logic [`DATA_W-1:0] r_pc;
  logic [`DATA_W-1:0] w_next;
  logic               w_hold;

  // Operands are chosen by a mux so an unselected X/Z operand never reaches r_pc.
  always_comb begin
    w_next = r_pc + 16'd1;
    if (bus.br_sel) begin
      if (bus.imr_sel)
        w_next = bus.rs;
      else
        w_next = r_pc + bus.imm;
    end
  end

`ifdef PC_STALL_EN
  assign w_hold = bus.stall;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!n_rst)
      r_pc <= RESET_PC;
    else if (!w_hold)
      r_pc <= w_next;
  end

  assign bus.out = r_pc;

endmodule

// File: tb/tb_pc.sv
// tb/tb_pc.sv - self-checking bench for pc against an arithmetic reference model.
`timescale 1ns/1ps

module tb_pc;
  logic clock = 1'b0;
  logic n_rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_pc = 0;

  pc_if bus ();

  pc u_dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] expv);
    tests++;
    assert (bus.out === expv) else begin
      fails++;
      $error("FAIL %s: out=%h expected=%h", tag, bus.out, expv);
    end
  endtask

  // Predict the edge from the inputs as they stand, then sample 1ns after it.
  task automatic tick(input string tag);
    int  t;
    logic st;
    st = 1'b0;
`ifdef PC_STALL_EN
    st = bus.stall;
`endif
    if (!n_rst)            t = 0;
    else if (st)           t = exp_pc;
    else if (!bus.br_sel)  t = exp_pc + 1;
    else if (bus.imr_sel)  t = int'(bus.rs);
    else                   t = exp_pc + int'($signed(bus.imm));
    exp_pc = ((t % 65536) + 65536) % 65536;
    @(posedge clock);
    #1;
    check(tag, exp_pc[15:0]);
  endtask

  task automatic branch_rs(input logic [15:0] v);
    bus.br_sel = 1'b1; bus.imr_sel = 1'b1; bus.rs = v;
    tick("br_rs");
    bus.br_sel = 1'b0;
  endtask

  initial begin
    bus.imm = '0; bus.rs = '0; bus.imr_sel = 1'b0; bus.br_sel = 1'b0;
`ifdef PC_STALL_EN
    bus.stall = 1'b0;
`endif
    n_rst = 1'b0;
    @(negedge clock);
    tick("reset");
    check("reset_const", 16'h0000);
    n_rst = 1'b1;

    for (int i = 0; i < 100; i++) tick("inc");
    check("inc100", 16'd100);

    // imr_sel is ignored while not branching; wrap past 0xFFFF
    bus.imr_sel = 1'b1;
    for (int i = 0; i < 5; i++) tick("inc_imr1");
    branch_rs(16'hFFFC);
    bus.imr_sel = 1'b1;
    for (int i = 0; i < 6; i++) tick("wrap");
    check("wrap_const", 16'h0002);

    branch_rs(16'h00C8);
    bus.imr_sel = 1'b0; bus.imm = 16'h0080; bus.br_sel = 1'b1;
    tick("rel_pos");
    check("rel_pos_const", 16'h0148);
    bus.br_sel = 1'b0;
    tick("after_rel"); check("after_rel_const", 16'h0149);
    tick("after_rel2"); check("after_rel2_const", 16'h014A);
    bus.imm = 16'hFFF0; bus.br_sel = 1'b1;
    tick("rel_neg"); check("rel_neg_const", 16'h013A);
    branch_rs(16'h0005);
    bus.imr_sel = 1'b0; bus.imm = 16'hFFF0; bus.br_sel = 1'b1;
    tick("rel_wrap_down"); check("rel_wrap_down_const", 16'hFFF5);
    tick("rel_repeat"); check("rel_repeat_const", 16'hFFE5);
    bus.br_sel = 1'b0;

    branch_rs(16'h8000); check("abs_const", 16'h8000);
    tick("abs_inc"); check("abs_inc_const", 16'h8001);
    branch_rs(16'hFFFF);
    tick("abs_wrap"); check("abs_wrap_const", 16'h0000);

    // unselected X operands must not leak into the PC
    bus.imm = 'x; bus.rs = 'x; bus.br_sel = 1'b0;
    tick("x_inc");
    bus.imm = 'x; bus.rs = 16'h1234; bus.br_sel = 1'b1; bus.imr_sel = 1'b1;
    tick("x_imm_unsel");
    bus.imm = 16'h0010; bus.rs = 'x; bus.imr_sel = 1'b0;
    tick("x_rs_unsel"); check("x_rs_unsel_const", 16'h1244);
    bus.rs = '0; bus.br_sel = 1'b0;

    for (int i = 0; i < 3; i++) tick("pre_rst");
    bus.br_sel = 1'b1; bus.imr_sel = 1'b1; bus.rs = 16'h4444; n_rst = 1'b0;
    tick("rst_over_br"); check("rst_over_br_const", 16'h0000);
    n_rst = 1'b1; bus.br_sel = 1'b0;
    tick("rst_release"); check("rst_release_const", 16'h0001);
    n_rst = 1'b0; #2; n_rst = 1'b1;
    tick("rst_glitch"); check("rst_glitch_const", 16'h0002);

`ifdef PC_STALL_EN
    bus.stall = 1'b1; bus.br_sel = 1'b1; bus.imr_sel = 1'b1; bus.rs = 16'h7777;
    tick("stall_br"); check("stall_br_const", 16'h0002);
    bus.br_sel = 1'b0;
    tick("stall_inc"); check("stall_inc_const", 16'h0002);
    n_rst = 1'b0;
    tick("stall_rst"); check("stall_rst_const", 16'h0000);
    n_rst = 1'b1; bus.stall = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      bus.br_sel  = ($urandom_range(0, 2) == 0);
      bus.imr_sel = $urandom_range(0, 1);
      bus.imm     = 16'($urandom);
      bus.rs      = 16'($urandom);
      n_rst       = ($urandom_range(0, 29) != 0);
`ifdef PC_STALL_EN
      bus.stall   = ($urandom_range(0, 4) == 0);
`endif
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: out=%h expected=finish", bus.out);
    $fatal(1, "timeout");
  end
endmodule
